// File: rtl/regfile_sb_if.sv
// Register-file bus: WB write port, two ID read ports and the issue/scoreboard signals.
// The master drives addresses, data and issue; the slave (register file) returns data and busy bits.
interface regfile_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic                   we;
    logic [ADDR_W-1:0]      waddr;
    logic [DATA_W-1:0]      wdata;
    logic [ADDR_W-1:0]      raddr0;
    logic [DATA_W-1:0]      rdata0;
    logic [ADDR_W-1:0]      raddr1;
    logic [DATA_W-1:0]      rdata1;
    logic                   iss_valid;
    logic [ADDR_W-1:0]      iss_rd;
    logic                   busy0;
    logic                   busy1;
    logic [2**ADDR_W-1:0]   busy_vec;

    modport master (
        output we, waddr, wdata, raddr0, raddr1, iss_valid, iss_rd,
        input  rdata0, rdata1, busy0, busy1, busy_vec
    );

    modport slave (
        input  we, waddr, wdata, raddr0, raddr1, iss_valid, iss_rd,
        output rdata0, rdata1, busy0, busy1, busy_vec
    );
endinterface

// File: rtl/regfile_sb.sv
// ID-stage register file: two combinational read ports with optional WB write-through bypass,
// one write port, and a per-register busy scoreboard for destinations awaiting writeback.
module regfile_sb #(
    parameter int unsigned        DATA_W = 32,
    parameter int unsigned        ADDR_W = 5,
    parameter int unsigned        SP_IDX = 29,
    parameter logic [DATA_W-1:0]  SP_RST = DATA_W'(32'h80),
    parameter bit                 BYPASS = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  bus
);
    localparam int unsigned NREG = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic              wr_en;
    logic              hit0;
    logic              hit1;

    // Register 0 is hardwired: writes to it are dropped and it is never bypassed.
    assign wr_en = bus.we && (bus.waddr != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_RST : '0;
            end
        end else if (wr_en) begin
            regs_q[bus.waddr] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A same-cycle issue wins over the clear: the newer producer owns the register.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[bus.waddr] = 1'b0;
        end
        if (bus.iss_valid) begin
            busy_d[bus.iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // The WB write resolving a hazard this cycle is forwarded, so it must not stall.
    assign hit0 = BYPASS && bus.we && (bus.waddr == bus.raddr0);
    assign hit1 = BYPASS && bus.we && (bus.waddr == bus.raddr1);

    always_comb begin
        bus.rdata0 = '0;
        if (bus.raddr0 != '0) begin
            bus.rdata0 = hit0 ? bus.wdata : regs_q[bus.raddr0];
        end
        bus.rdata1 = '0;
        if (bus.raddr1 != '0) begin
            bus.rdata1 = hit1 ? bus.wdata : regs_q[bus.raddr1];
        end
    end

    assign bus.busy0    = busy_q[bus.raddr0] && !hit0;
    assign bus.busy1    = busy_q[bus.raddr1] && !hit1;
    assign bus.busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a BYPASS=1 and a BYPASS=0 instance share one stimulus stream and are
// compared every cycle against an array-based model, plus directed literal checks.
module tb_regfile_sb;
    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr0;
    logic [4:0]  raddr1;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        cmp_en;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();
    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus_n ();

    assign bus_b.we = we;           assign bus_n.we = we;
    assign bus_b.waddr = waddr;     assign bus_n.waddr = waddr;
    assign bus_b.wdata = wdata;     assign bus_n.wdata = wdata;
    assign bus_b.raddr0 = raddr0;   assign bus_n.raddr0 = raddr0;
    assign bus_b.raddr1 = raddr1;   assign bus_n.raddr1 = raddr1;
    assign bus_b.iss_valid = iss_valid; assign bus_n.iss_valid = iss_valid;
    assign bus_b.iss_rd = iss_rd;   assign bus_n.iss_rd = iss_rd;

    regfile_sb #(.BYPASS(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    regfile_sb #(.BYPASS(1'b0)) dut_n (.clk(clk), .reset(reset), .bus(bus_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: architectural register values and pending-writeback flags.
    logic [31:0] m_mem [32];
    logic [31:0] m_busy;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_mem[i] <= (i == 29) ? 32'h80 : 32'h0;
            m_busy <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (iss_valid && iss_rd == 5'(i)) m_busy[i] <= 1'b1;
                else if (we && waddr == 5'(i)) m_busy[i] <= 1'b0;
                if (we && waddr == 5'(i)) m_mem[i] <= wdata;
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && we && waddr == a) return wdata;
        return m_mem[a];
    endfunction

    function automatic logic exp_bz(input logic [4:0] a, input bit byp);
        return m_busy[a] && !(byp && we && waddr == a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("b.rdata0", 64'(bus_b.rdata0), 64'(exp_rd(raddr0, 1'b1)));
            chk("b.rdata1", 64'(bus_b.rdata1), 64'(exp_rd(raddr1, 1'b1)));
            chk("b.busy0", 64'(bus_b.busy0), 64'(exp_bz(raddr0, 1'b1)));
            chk("b.busy1", 64'(bus_b.busy1), 64'(exp_bz(raddr1, 1'b1)));
            chk("b.busy_vec", 64'(bus_b.busy_vec), 64'(m_busy));
            chk("n.rdata0", 64'(bus_n.rdata0), 64'(exp_rd(raddr0, 1'b0)));
            chk("n.rdata1", 64'(bus_n.rdata1), 64'(exp_rd(raddr1, 1'b0)));
            chk("n.busy0", 64'(bus_n.busy0), 64'(exp_bz(raddr0, 1'b0)));
            chk("n.busy1", 64'(bus_n.busy1), 64'(exp_bz(raddr1, 1'b0)));
            chk("n.busy_vec", 64'(bus_n.busy_vec), 64'(m_busy));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; iss_valid = 1'b0; waddr = '0; wdata = '0; iss_rd = '0;
    endtask

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        cmp_en = 1'b0;
        reset  = 1'b0;
        raddr0 = '0;
        raddr1 = '0;
        idle();
        #1 reset = 1'b1;
        cmp_en = 1'b1;

        // Reset contents sweep: only the stack pointer is non-zero.
        for (int i = 0; i < 16; i++) begin
            raddr0 = 5'(i);
            raddr1 = 5'(i + 16);
            #2;
            chk("rst.rdata0", 64'(bus_b.rdata0), 64'h0);
            chk("rst.rdata1", 64'(bus_b.rdata1), (i + 16 == 29) ? 64'h80 : 64'h0);
            chk("rst.busy_vec", 64'(bus_b.busy_vec), 64'h0);
            step();
        end
        reset = 1'b0;

        // Plain write then read; register 0 ignores writes and bypass.
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        step();
        idle(); raddr0 = 5'd5; #2;
        chk("wr.rdata0", 64'(bus_b.rdata0), 64'hDEADBEEF);
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr0 = 5'd0; #2;
        chk("r0.nobypass", 64'(bus_b.rdata0), 64'h0);
        step();
        idle(); #2;
        chk("r0.zero", 64'(bus_b.rdata0), 64'h0);

        // Same-cycle bypass visible only on the BYPASS=1 instance.
        we = 1'b1; waddr = 5'd7; wdata = 32'h1234; raddr1 = 5'd7; #2;
        chk("byp.rdata1", 64'(bus_b.rdata1), 64'h1234);
        chk("nobyp.rdata1", 64'(bus_n.rdata1), 64'h0);
        step();
        idle(); #2;
        chk("wr7.nobyp", 64'(bus_n.rdata1), 64'h1234);

        // Scoreboard set, bypassed clear, then cleared bit.
        iss_valid = 1'b1; iss_rd = 5'd3;
        step();
        idle(); raddr0 = 5'd3; #2;
        chk("sb.vec3", 64'(bus_b.busy_vec[3]), 64'h1);
        chk("sb.busy0", 64'(bus_b.busy0), 64'h1);
        we = 1'b1; waddr = 5'd3; wdata = 32'h33; #2;
        chk("sb.busy0.wb", 64'(bus_b.busy0), 64'h0);
        chk("sb.busy0.nobyp", 64'(bus_n.busy0), 64'h1);
        step();
        idle(); #2;
        chk("sb.cleared", 64'(bus_b.busy_vec[3]), 64'h0);

        // Issue beats a simultaneous writeback; register 0 is never busy.
        iss_valid = 1'b1; iss_rd = 5'd4; we = 1'b1; waddr = 5'd4; wdata = 32'h44;
        step();
        idle(); #2;
        chk("sim.vec4", 64'(bus_b.busy_vec[4]), 64'h1);
        iss_valid = 1'b1; iss_rd = 5'd0;
        step();
        idle(); #2;
        chk("sim.vec0", 64'(bus_b.busy_vec[0]), 64'h0);

        // Randomized traffic with frequent address collisions.
        for (int c = 0; c < 600; c++) begin
            we        = ($urandom_range(0, 1) == 1);
            waddr     = rnd_addr();
            wdata     = $urandom;
            iss_valid = ($urandom_range(0, 4) < 2);
            iss_rd    = rnd_addr();
            raddr0    = rnd_addr();
            raddr1    = rnd_addr();
            step();
        end

        // Fill every register, mark several busy, then reset between clock edges.
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'hA500_0000 | 32'(i);
            iss_valid = 1'b1; iss_rd = 5'(32 - i);
            step();
        end
        idle(); raddr0 = 5'd29; raddr1 = 5'd5;
        step();
        reset = 1'b1; #2;
        chk("arst.sp", 64'(bus_b.rdata0), 64'h80);
        chk("arst.r5", 64'(bus_b.rdata1), 64'h0);
        chk("arst.busy_vec", 64'(bus_b.busy_vec), 64'h0);
        #4 reset = 1'b0;

        for (int c = 0; c < 200; c++) begin
            we        = ($urandom_range(0, 1) == 1);
            waddr     = rnd_addr();
            wdata     = $urandom;
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_rd    = rnd_addr();
            raddr0    = rnd_addr();
            raddr1    = rnd_addr();
            step();
        end
        idle();
        step();
        @(negedge clk);
        #1 cmp_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
